// File: rtl/gray_to_bin_tracker.sv
// Read-side decoder for a Gray count from a foreign clock domain. The count is
// synchronized, converted to binary, and each change is classified as a step or an error.
module gray_to_bin_tracker #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             ready,
    output logic             step_valid,
    output logic             dir_up,
    output logic             err,
    output logic             err_sticky
);

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] FILL_MAX = CW'(SYNC_STAGES);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] g_cur;
    logic [WIDTH-1:0] g_prev;
    logic [WIDTH-1:0] bin_cur;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] diff;
    logic [CW-1:0]    fill;
    logic             single;
    logic             multi;

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign g_cur    = sync_q[SYNC_STAGES-1];
    assign bin_cur  = g2b(g_cur);
    assign bin_next = g2b(g_prev) + 1'b1;
    assign diff     = g_cur ^ g_prev;
    // A non-zero power of two means exactly one Gray bit moved.
    assign single   = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
    assign multi    = (diff != '0) && !single;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // ready rises one edge after the fill counter saturates, once the chain holds real samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill  <= '0;
            ready <= 1'b0;
        end else begin
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
            if (fill == FILL_MAX) begin
                ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_prev     <= '0;
            bin_out    <= '0;
            step_valid <= 1'b0;
            dir_up     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            bin_out <= bin_cur;
            g_prev  <= g_cur;
            if (ready) begin
                step_valid <= single;
                err        <= multi;
                if (single) begin
                    dir_up <= (bin_cur == bin_next);
                end
            end else begin
                step_valid <= 1'b0;
                err        <= 1'b0;
            end
            // A fresh error wins over a simultaneous clear request.
            if (ready && multi) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_to_bin_tracker.sv
// Bench for gray_to_bin_tracker: an edge-indexed history model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_gray_to_bin_tracker;

    localparam int SS = 2;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic       err_clr;
    logic [3:0] bin_out;
    logic       ready;
    logic       step_valid;
    logic       dir_up;
    logic       err;
    logic       err_sticky;

    int passed = 0;
    int total  = 0;

    gray_to_bin_tracker #(.WIDTH(4), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .gray_in    (gray_in),
        .err_clr    (err_clr),
        .bin_out    (bin_out),
        .ready      (ready),
        .step_valid (step_valid),
        .dir_up     (dir_up),
        .err        (err),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mem holds the gray_in sampled at each edge number since reset.
    bit [3:0] mem [8];
    int       n;
    logic [3:0] m_bin;
    logic       m_ready, m_step, m_dir, m_err, m_sticky;

    function automatic logic [3:0] to_bin(input logic [3:0] g);
        logic [3:0] b;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            b = b ^ (g >> k);
        end
        return b;
    endfunction

    function automatic logic [3:0] gdel(input int e);
        if (e > SS) return mem[(e - SS) % 8];
        return 4'd0;
    endfunction

    function automatic int jump(input int e);
        return $countones(gdel(e) ^ gdel(e - 1));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n        <= 0;
            m_bin    <= '0;
            m_ready  <= 1'b0;
            m_step   <= 1'b0;
            m_dir    <= 1'b0;
            m_err    <= 1'b0;
            m_sticky <= 1'b0;
        end else begin
            n                  <= n + 1;
            mem[(n + 1) % 8]   <= gray_in;
            m_bin              <= to_bin(gdel(n + 1));
            m_ready            <= (n + 1 >= SS + 1);
            if (n >= SS + 1) begin
                m_step <= (jump(n + 1) == 1);
                m_err  <= (jump(n + 1) >= 2);
                if (jump(n + 1) == 1)
                    m_dir <= (to_bin(gdel(n + 1)) == 4'((to_bin(gdel(n)) + 1) % 16));
                m_sticky <= (jump(n + 1) >= 2) ? 1'b1 : (err_clr ? 1'b0 : m_sticky);
            end else begin
                m_step   <= 1'b0;
                m_err    <= 1'b0;
                m_sticky <= err_clr ? 1'b0 : m_sticky;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic [3:0] g, input logic c, input int cycles);
        gray_in = g;
        err_clr = c;
        repeat (cycles) @(negedge clk);
    endtask

    // Every cycle out of reset, the full output set must agree with the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0)
                checkOutput("model", {7'd0, bin_out, ready, step_valid, dir_up, err, err_sticky},
                            {7'd0, m_bin, m_ready, m_step, m_dir, m_err, m_sticky});
        end
    end

    initial begin
        logic [3:0] g;
        rst     = 1'b1;
        gray_in = 4'b0000;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus(4'b0000, 1'b0, 2);
        checkOutput("t1_ready_early", {15'd0, ready}, 16'd0);
        applyStimulus(4'b0000, 1'b0, 1);
        checkOutput("t1_ready", {15'd0, ready}, 16'd1);
        checkOutput("t1_bin", {12'd0, bin_out}, 16'd0);
        checkOutput("t1_quiet", {14'd0, step_valid, err}, 16'd0);

        for (int i = 1; i < 16; i++) begin
            g = 4'(i ^ (i >> 1));
            applyStimulus(g, 1'b0, 3);
            checkOutput("t2_bin", {12'd0, bin_out}, 16'(i));
            checkOutput("t2_step_dir", {14'd0, step_valid, dir_up}, 16'b11);
            applyStimulus(g, 1'b0, 1);
            checkOutput("t2_step_drop", {15'd0, step_valid}, 16'd0);
        end
        applyStimulus(4'b0000, 1'b0, 3);
        checkOutput("t2_wrap", {11'd0, bin_out, step_valid}, {11'd0, 4'd0, 1'b1});
        checkOutput("t2_wrap_dir", {15'd0, dir_up}, 16'd1);
        applyStimulus(4'b0000, 1'b0, 1);

        applyStimulus(4'b0010, 1'b0, 4);
        checkOutput("t3_bin3", {12'd0, bin_out}, 16'd3);
        applyStimulus(4'b0011, 1'b0, 3);
        checkOutput("t3_down", {10'd0, bin_out, step_valid, dir_up}, {10'd0, 4'd2, 2'b10});
        applyStimulus(4'b0011, 1'b0, 1);
        applyStimulus(4'b0001, 1'b0, 4);
        applyStimulus(4'b0000, 1'b0, 4);
        applyStimulus(4'b1000, 1'b0, 3);
        checkOutput("t3_wrap_down", {10'd0, bin_out, step_valid, dir_up}, {10'd0, 4'd15, 2'b10});
        applyStimulus(4'b1000, 1'b0, 1);

        applyStimulus(4'b0000, 1'b0, 4);
        applyStimulus(4'b0011, 1'b0, 3);
        checkOutput("t4_jump", {9'd0, bin_out, err, err_sticky, step_valid}, {9'd0, 4'd2, 3'b110});
        applyStimulus(4'b0011, 1'b0, 1);
        checkOutput("t4_err_drop", {14'd0, err, err_sticky}, 16'b01);
        applyStimulus(4'b0011, 1'b1, 1);
        checkOutput("t4_clear", {15'd0, err_sticky}, 16'd0);
        applyStimulus(4'b0101, 1'b0, 2);
        applyStimulus(4'b0101, 1'b1, 1);
        checkOutput("t4_clr_vs_err", {10'd0, bin_out, err, err_sticky}, {10'd0, 4'd6, 2'b11});
        applyStimulus(4'b0101, 1'b0, 1);
        checkOutput("t4_hold", {15'd0, err_sticky}, 16'd1);

        applyStimulus(4'b0100, 1'b0, 4);
        applyStimulus(4'b0110, 1'b0, 2);
        rst = 1'b1;
        #1;
        checkOutput("t5_async", {7'd0, bin_out, ready, step_valid, dir_up, err, err_sticky}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b0110, 1'b0, 2);
        checkOutput("t5_ready_early", {15'd0, ready}, 16'd0);
        applyStimulus(4'b0110, 1'b0, 1);
        checkOutput("t5_primed", {9'd0, bin_out, ready, err, step_valid}, {9'd0, 4'd4, 3'b100});

        applyStimulus(4'b0000, 1'b0, 4);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0011, 1'b0, 1);
        applyStimulus(4'b0010, 1'b0, 1);
        checkOutput("t6_step1", {10'd0, bin_out, step_valid, dir_up}, {10'd0, 4'd1, 2'b11});
        applyStimulus(4'b0010, 1'b0, 1);
        checkOutput("t6_step2", {10'd0, bin_out, step_valid, dir_up}, {10'd0, 4'd2, 2'b11});
        applyStimulus(4'b0010, 1'b0, 1);
        checkOutput("t6_step3", {10'd0, bin_out, step_valid, dir_up}, {10'd0, 4'd3, 2'b11});
        applyStimulus(4'b0010, 1'b0, 1);
        checkOutput("t6_idle", {15'd0, step_valid}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
